data_mem_arbiter: RTL and testbench
===================================

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 18, data word width.
REQ-002 SHALL have parameter STARVE_LIMIT, default 15, consecutive denied debug-request cycles before forced debug grant (4-bit counter; legal 1..15).
REQ-003 SHALL have port clock  input  1  single system clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports cpu_req/cpu_wren  input  1 each  processor access request / write enable.
REQ-006 SHALL have ports cpu_address  input  16, cpu_write  input  WORD_SIZE  processor address / write data.
REQ-007 SHALL have ports cpu_grant  output  1, cpu_read  output  WORD_SIZE, cpu_read_valid  output  1.
REQ-008 SHALL have ports dbg_req, dbg_wren, dbg_lock  input  1 each  debug-controller request / write enable / hold ownership.
REQ-009 SHALL have ports dbg_address  input  16, dbg_write  input  WORD_SIZE.
REQ-010 SHALL have ports dbg_grant  output  1, dbg_read  output  WORD_SIZE, dbg_read_valid  output  1.
REQ-011 SHALL have ports mem_address  output  16, mem_write  output  WORD_SIZE, mem_wren  output  1, mem_read  input  WORD_SIZE  single-port synchronous RAM, 1-cycle read latency.

Function
REQ-012 SHALL implement FSM states IDLE, CPU, DBG, DBG_LOCK; state = owner of the access issued in the previous cycle.
REQ-013 SHALL compute grant combinationally in the same cycle as req; at most one of cpu_grant/dbg_grant high per cycle.
REQ-014 SHALL, in IDLE/CPU/DBG: grant CPU if cpu_req, else debug if dbg_req, else none (subject to REQ-020).
REQ-015 SHALL enter DBG_LOCK when debug is granted with dbg_lock=1; in DBG_LOCK grant only debug, cpu_grant=0 even if cpu_req=1.
REQ-016 SHALL leave DBG_LOCK when dbg_lock=0: to DBG if dbg_req granted that cycle, else per REQ-014 that same cycle.
REQ-017 SHALL drive mem_address/mem_write/mem_wren from the granted requester; with no grant mem_wren=0 and mem_address holds last driven value.
REQ-018 SHALL assert <req>_read_valid exactly one cycle after a granted read (wren=0), with <req>_read = mem_read; no read_valid for writes.
REQ-019 SHALL keep cpu_read/dbg_read equal to the last delivered value when read_valid=0.
REQ-020 SHALL maintain starve counter: increment (saturating at 15) each cycle dbg_req=1 and dbg_grant=0; clear on dbg_grant or dbg_req=0.
REQ-021 SHALL treat a request deasserted without grant as withdrawn; no queuing.
REQ-022 SHALL allow back-to-back grants to alternating requesters every cycle with no bubble.

Reset
REQ-023 SHALL, while reset=1, asynchronously force state IDLE, cpu_grant=dbg_grant=0, mem_wren=0, both read_valid=0, mem_address=0, starve counter=0, cpu_read=dbg_read=0.
REQ-024 SHALL discard a read in flight when reset asserts; no read_valid after reset release for it.
REQ-025 SHALL produce no grant in the cycle reset deasserts if requests are low; first grant follows REQ-014 thereafter.

Configuration
REQ-026 SHALL compile starvation guard only when macro DATA_MEM_ARB_STARVE_GUARD_EN is defined.
REQ-027 SHALL, with DATA_MEM_ARB_STARVE_GUARD_EN defined, grant debug over CPU for one access when starve counter >= STARVE_LIMIT, then clear counter.
REQ-028 SHALL, without DATA_MEM_ARB_STARVE_GUARD_EN, use strict CPU priority (outside DBG_LOCK) and omit the counter.

Verification
REQ-029 SHALL cover: cpu_req and dbg_req both 1, read at 0x0010 (mem holds 0x2AAAA) -> cpu_grant=1, next cycle cpu_read=0x2AAAA, cpu_read_valid=1, dbg_grant=0.
REQ-030 SHALL cover: dbg_req=1,dbg_lock=1 for 4 writes 0x0100..0x0103 with cpu_req=1 throughout -> dbg_grant 4 cycles, cpu_grant=0, mem_wren=1 each cycle; CPU granted cycle after dbg_lock=0.
REQ-031 SHALL cover: guard enabled, STARVE_LIMIT=3, cpu_req and dbg_req held 1 -> dbg_grant=1 on 4th cycle only, then CPU resumes; guard disabled -> dbg_grant never 1.
REQ-032 SHALL cover: alternating cpu read 0x0001 / dbg read 0x0002 each cycle -> read_valid pulses alternate, each data matches its address, no lost cycles.
REQ-033 SHALL cover: reset asserted the cycle after granted dbg read -> dbg_read_valid stays 0, all outputs at reset values asynchronously.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares one single-port synchronous RAM (1-cycle read
// latency) between a processor port and a debug-controller port.
// Grants are combinational in the request cycle; read data returns one cycle
// later on the port that issued the read.
// Optional starvation guard: define DATA_MEM_ARB_STARVE_GUARD_EN.
module data_mem_arbiter #(
  parameter int WORD_SIZE    = 18,
  parameter int STARVE_LIMIT = 15
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cpu_req,
  input  logic                 cpu_wren,
  input  logic [15:0]          cpu_address,
  input  logic [WORD_SIZE-1:0] cpu_write,
  output logic                 cpu_grant,
  output logic [WORD_SIZE-1:0] cpu_read,
  output logic                 cpu_read_valid,
  input  logic                 dbg_req,
  input  logic                 dbg_wren,
  input  logic                 dbg_lock,
  input  logic [15:0]          dbg_address,
  input  logic [WORD_SIZE-1:0] dbg_write,
  output logic                 dbg_grant,
  output logic [WORD_SIZE-1:0] dbg_read,
  output logic                 dbg_read_valid,
  output logic [15:0]          mem_address,
  output logic [WORD_SIZE-1:0] mem_write,
  output logic                 mem_wren,
  input  logic [WORD_SIZE-1:0] mem_read
);

  // The starve counter is 4 bits wide, so only 1..15 is meaningful.
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_limit_check
    $error("data_mem_arbiter: STARVE_LIMIT must be in 1..15");
  end

  // State records who owned the access issued in the previous cycle.
  typedef enum logic [1:0] {IDLE, CPU, DBG, DBG_LOCK} state_t;

  state_t               state, state_next;
  logic [15:0]          addr_q;
  logic                 cpu_pend, dbg_pend;
  logic [WORD_SIZE-1:0] cpu_read_q, dbg_read_q;
  logic                 starved;

`ifdef DATA_MEM_ARB_STARVE_GUARD_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [3:0] starve_cnt;

  assign starved = dbg_req && (starve_cnt >= LIMIT);

  // Count consecutive cycles debug asked and was refused; saturates at 15.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      starve_cnt <= '0;
    else if (!dbg_req || dbg_grant)
      starve_cnt <= '0;
    else if (starve_cnt != 4'hF)
      starve_cnt <= starve_cnt + 4'd1;
  end
`else
  assign starved = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Grant decision and next owner. While locked, debug keeps the bus as long
  // as it holds lock or still requests; once both drop, normal priority
  // applies in that same cycle.
  always_comb begin
    cpu_grant  = 1'b0;
    dbg_grant  = 1'b0;
    state_next = IDLE;
    if (!reset) begin
      if (state == DBG_LOCK && (dbg_req || dbg_lock))
        dbg_grant = dbg_req;
      else if (starved)
        dbg_grant = 1'b1;
      else if (cpu_req)
        cpu_grant = 1'b1;
      else if (dbg_req)
        dbg_grant = 1'b1;

      if (cpu_grant)
        state_next = CPU;
      else if (dbg_grant)
        state_next = dbg_lock ? DBG_LOCK : DBG;
      else if (state == DBG_LOCK && dbg_lock)
        state_next = DBG_LOCK;
    end
  end

  // Memory port steering; the address parks on the last driven value.
  assign mem_address = dbg_grant ? dbg_address :
                       cpu_grant ? cpu_address : addr_q;
  assign mem_write   = dbg_grant ? dbg_write : cpu_write;
  assign mem_wren    = (cpu_grant && cpu_wren) || (dbg_grant && dbg_wren);

  // Remember the last address put on the bus.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                       addr_q <= '0;
    else if (cpu_grant || dbg_grant) addr_q <= mem_address;
  end

  // Track reads in flight; reset drops them so no stale valid appears.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cpu_pend <= 1'b0;
      dbg_pend <= 1'b0;
    end else begin
      cpu_pend <= cpu_grant && !cpu_wren;
      dbg_pend <= dbg_grant && !dbg_wren;
    end
  end

  // Capture delivered read data so the read outputs hold between pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cpu_read_q <= '0;
      dbg_read_q <= '0;
    end else begin
      if (cpu_pend) cpu_read_q <= mem_read;
      if (dbg_pend) dbg_read_q <= mem_read;
    end
  end

  assign cpu_read_valid = cpu_pend;
  assign dbg_read_valid = dbg_pend;
  assign cpu_read       = cpu_pend ? mem_read : cpu_read_q;
  assign dbg_read       = dbg_pend ? mem_read : dbg_read_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: randomized and directed traffic,
// a behavioural ownership/memory model, and a read-data scoreboard.
module tb_data_mem_arbiter;
  localparam int W = 18;
`ifdef DATA_MEM_ARB_STARVE_GUARD_EN
  localparam int LIMIT = 3;
  localparam bit GUARD = 1'b1;
`else
  localparam int LIMIT = 15;
  localparam bit GUARD = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          cpu_req = 1'b0, cpu_wren = 1'b0;
  logic [15:0]   cpu_address = '0;
  logic [W-1:0]  cpu_write = '0;
  logic          cpu_grant, cpu_read_valid;
  logic [W-1:0]  cpu_read;
  logic          dbg_req = 1'b0, dbg_wren = 1'b0, dbg_lock = 1'b0;
  logic [15:0]   dbg_address = '0;
  logic [W-1:0]  dbg_write = '0;
  logic          dbg_grant, dbg_read_valid;
  logic [W-1:0]  dbg_read;
  logic [15:0]   mem_address;
  logic [W-1:0]  mem_write;
  logic          mem_wren;
  logic [W-1:0]  mem_read;

  always #5 clock = ~clock;

  data_mem_arbiter #(.WORD_SIZE(W), .STARVE_LIMIT(LIMIT)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_wren(cpu_wren), .cpu_address(cpu_address),
    .cpu_write(cpu_write), .cpu_grant(cpu_grant), .cpu_read(cpu_read),
    .cpu_read_valid(cpu_read_valid),
    .dbg_req(dbg_req), .dbg_wren(dbg_wren), .dbg_lock(dbg_lock),
    .dbg_address(dbg_address), .dbg_write(dbg_write), .dbg_grant(dbg_grant),
    .dbg_read(dbg_read), .dbg_read_valid(dbg_read_valid),
    .mem_address(mem_address), .mem_write(mem_write), .mem_wren(mem_wren),
    .mem_read(mem_read)
  );

  function automatic logic [W-1:0] init_word(input int unsigned a);
    if (a == 16) return 18'h2AAAA;
    return W'((a * 32'h9E37) ^ 32'h155);
  endfunction

  // Synchronous single-port RAM, read-first, 1-cycle latency.
  logic [W-1:0] ram [0:511];
  always begin : ram_model
    for (int i = 0; i < 512; i++) ram[i] = init_word(i);
    forever begin
      @(posedge clock);
      if (mem_wren) ram[mem_address[8:0]] <= mem_write;
      mem_read <= ram[mem_address[8:0]];
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state.
  logic [W-1:0] ref_mem [0:511];
  logic [W-1:0] cpu_q[$];
  logic [W-1:0] dbg_q[$];
  logic [W-1:0] cpu_last = '0, dbg_last = '0;
  bit           m_locked = 1'b0;
  int           m_denied = 0;
  logic [15:0]  m_addr = '0;

  // Scoreboard monitor: pops an expected word whenever read_valid appears.
  initial begin : monitor
    logic [W-1:0] exp;
    forever begin
      @(negedge clock);
      if (reset) begin
        cpu_last = '0;
        dbg_last = '0;
      end
      if (cpu_read_valid === 1'b1) begin
        if (cpu_q.size() == 0) check("cpu_read_valid_spurious", 64'(cpu_read_valid), 64'd0);
        else begin
          exp = cpu_q.pop_front();
          cpu_last = exp;
          check("cpu_read", 64'(cpu_read), 64'(exp));
        end
      end else check("cpu_read_hold", 64'(cpu_read), 64'(cpu_last));
      if (dbg_read_valid === 1'b1) begin
        if (dbg_q.size() == 0) check("dbg_read_valid_spurious", 64'(dbg_read_valid), 64'd0);
        else begin
          exp = dbg_q.pop_front();
          dbg_last = exp;
          check("dbg_read", 64'(dbg_read), 64'(exp));
        end
      end else check("dbg_read_hold", 64'(dbg_read), 64'(dbg_last));
    end
  end

  // One bus cycle: drive requests, predict ownership, check, update model.
  task automatic step(input bit cr, input bit cw, input logic [15:0] ca, input logic [W-1:0] cd,
                      input bit dr, input bit dw, input bit dl, input logic [15:0] da,
                      input logic [W-1:0] dd);
    bit debug_holds, debug_starving, gc, gd, ew;
    logic [15:0] ea;
    @(negedge clock);
    cpu_req = cr; cpu_wren = cw; cpu_address = ca; cpu_write = cd;
    dbg_req = dr; dbg_wren = dw; dbg_lock = dl; dbg_address = da; dbg_write = dd;
    // Debug keeps a locked bus while it requests or holds lock; a debug port
    // refused LIMIT times in a row wins once; otherwise the processor wins.
    debug_holds    = m_locked && (dr || dl);
    debug_starving = GUARD && dr && (m_denied >= LIMIT);
    gd = debug_holds ? dr : (debug_starving || (dr && !cr));
    gc = !debug_holds && !debug_starving && cr;
    ea = gd ? da : (gc ? ca : m_addr);
    ew = gd ? dw : (gc ? cw : 1'b0);
    #1;
    check("grant_bus", 64'({cpu_grant, dbg_grant, mem_wren, mem_address}),
          64'({gc, gd, ew, ea}));
    if (ew) check("mem_write", 64'(mem_write), 64'(gd ? dd : cd));
    if (gc) begin
      if (cw) ref_mem[ca[8:0]] = cd;
      else    cpu_q.push_back(ref_mem[ca[8:0]]);
    end
    if (gd) begin
      if (dw) ref_mem[da[8:0]] = dd;
      else    dbg_q.push_back(ref_mem[da[8:0]]);
    end
    m_addr   = ea;
    m_locked = gd ? dl : (gc ? 1'b0 : (m_locked && dl));
    m_denied = (dr && !gd) ? ((m_denied < 15) ? m_denied + 1 : 15) : 0;
  endtask

  task automatic idle();
    step(0, 0, 16'h0, '0, 0, 0, 0, 16'h0, '0);
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, 64'({cpu_grant, dbg_grant, mem_wren, cpu_read_valid, dbg_read_valid,
                     mem_address, cpu_read, dbg_read}), 64'd0);
  endtask

  initial begin : stimulus
    for (int i = 0; i < 512; i++) ref_mem[i] = init_word(i);

    // Power-on reset.
    #3 check_reset_outputs("reset_state");
    @(negedge clock); @(negedge clock);
    reset = 1'b0;
    idle();                              // no grant right after release

    // Both request; processor wins and reads the preset word.
    step(1, 0, 16'h0010, '0, 1, 0, 0, 16'h0003, '0);
    idle();

    // Debug takes a lock, then writes 0x100..0x103 while the CPU keeps asking.
    step(0, 0, 16'h0, '0, 1, 0, 1, 16'h0004, '0);
    for (int unsigned k = 0; k < 4; k++)
      step(1, 0, 16'h0005, '0, 1, 1, 1, 16'(16'h0100 + k), W'(18'h1_0000 + k));
    step(1, 0, 16'h0100, '0, 0, 0, 0, 16'h0, '0);   // lock released: CPU granted
    for (int unsigned k = 1; k < 4; k++)
      step(1, 0, 16'(16'h0100 + k), '0, 0, 0, 0, 16'h0, '0);
    idle();

    // Alternating CPU/debug reads every cycle, no bubbles.
    for (int unsigned k = 0; k < 8; k++) begin
      if (k % 2 == 0) step(1, 0, 16'h0001, '0, 0, 0, 0, 16'h0, '0);
      else            step(0, 0, 16'h0, '0, 1, 0, 0, 16'h0002, '0);
    end
    idle();

    // Both held: debug only wins when the guard is built in.
    for (int unsigned k = 0; k < 10; k++)
      step(1, 0, 16'(k), '0, 1, 0, 0, 16'(k + 8), '0);
    idle();

    // Random traffic.
    for (int unsigned k = 0; k < 400; k++)
      step($urandom_range(0, 99) < 60, $urandom_range(0, 1) == 1, 16'($urandom_range(0, 7)),
           W'($urandom), $urandom_range(0, 99) < 50, $urandom_range(0, 1) == 1,
           $urandom_range(0, 9) < 2, 16'($urandom_range(0, 7)), W'($urandom));
    step(0, 0, 16'h0, '0, 0, 0, 0, 16'h0, '0);
    idle();
    idle();

    // Reset lands while a granted debug read is in flight.
    step(0, 0, 16'h0, '0, 1, 0, 0, 16'h0002, '0);
    @(posedge clock);
    #1 reset = 1'b1;
    cpu_q.delete();
    dbg_q.delete();
    m_locked = 1'b0;
    m_denied = 0;
    m_addr   = '0;
    #1 check_reset_outputs("async_reset");
    cpu_req = 1'b0; dbg_req = 1'b0; dbg_lock = 1'b0;
    @(negedge clock); @(negedge clock);
    reset = 1'b0;
    idle();
    idle();
    step(1, 0, 16'h0006, '0, 0, 0, 0, 16'h0, '0);
    idle();
    idle();

    check("cpu_reads_delivered", 64'(cpu_q.size()), 64'd0);
    check("dbg_reads_delivered", 64'(dbg_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
